// File: rtl/tile_pkg.sv
// Shared tile codes, FSM state type and the built-in level images for tile_map.
package tile_pkg;

    localparam int IMG_COLS   = 8;
    localparam int IMG_ROWS   = 8;
    localparam int IMG_CELLS  = IMG_COLS * IMG_ROWS;
    localparam int IMG_LEVELS = 2;
    localparam int IMG_W      = 2;

    localparam logic [IMG_W-1:0] EMPTY  = 2'd0;
    localparam logic [IMG_W-1:0] TARGET = 2'd1;

    typedef enum logic {
        LOAD,
        IDLE
    } state_t;

    typedef logic [IMG_LEVELS-1:0][IMG_CELLS-1:0][IMG_W-1:0] images_t;

    // Level 0: a row of six targets along the bottom edge; level 1: empty board.
    function automatic images_t build_images();
        images_t img;
        img = '0;
        for (int c = 0; c < 6; c++) begin
            img[0][7*IMG_COLS + c] = TARGET;
        end
        return img;
    endfunction

    localparam images_t LEVEL_IMAGES = build_images();

endpackage

// File: rtl/tile_level_rom.sv
// Combinational lookup of the stored initial level images: (level, index) -> tile code.
module tile_level_rom
    import tile_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int TYPE_W     = 2,
    parameter int NUM_LEVELS = 2,
    parameter int IW         = $clog2(COLS*ROWS),
    parameter int LW         = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic [LW-1:0]     level,
    input  logic [IW-1:0]     index,
    output logic [TYPE_W-1:0] code
);

    // Cells outside the stored image geometry read as EMPTY.
    always_comb begin
        code = '0;
        if (int'(level) < IMG_LEVELS && int'(index) < IMG_CELLS) begin
            code = TYPE_W'(LEVEL_IMAGES[level][index]);
        end
    end

endmodule

// File: rtl/tile_map.sv
// Tile grid with level loading, single-port writes, registered reads and live target counting.
module tile_map
    import tile_pkg::*;
#(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int TYPE_W      = 2,
    parameter int NUM_LEVELS  = 2,
    parameter int TARGET_TYPE = 1,
    parameter int XW          = $clog2(COLS),
    parameter int YW          = $clog2(ROWS),
    parameter int LW          = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    parameter int CW          = $clog2(COLS*ROWS+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XW-1:0]     Xnum,
    input  logic [YW-1:0]     Ynum,
    output logic [TYPE_W-1:0] Tile_Type,
    input  logic              wr_en,
    input  logic [XW-1:0]     wr_x,
    input  logic [YW-1:0]     wr_y,
    input  logic [TYPE_W-1:0] wr_type,
    input  logic              load_req,
    input  logic [LW-1:0]     level_sel,
    output logic              busy,
    output logic [CW-1:0]     target_count,
    output logic              level_done
);

    localparam int CELLS = COLS * ROWS;
    localparam int IW    = $clog2(CELLS);
    localparam logic [TYPE_W-1:0] TGT = TYPE_W'(TARGET_TYPE);

    state_t            state;
    logic [IW-1:0]     load_idx;
    logic [LW-1:0]     load_lvl;
    logic [TYPE_W-1:0] rom_code;
    logic [TYPE_W-1:0] cells [CELLS];

    logic              rd_ok;
    logic              wr_ok;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     wr_idx;
    logic              wr_fire;
    logic [TYPE_W-1:0] old_code;

    tile_level_rom #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .TYPE_W     (TYPE_W),
        .NUM_LEVELS (NUM_LEVELS),
        .IW         (IW),
        .LW         (LW)
    ) u_rom (
        .level (load_lvl),
        .index (load_idx),
        .code  (rom_code)
    );

    assign rd_ok    = (int'(Xnum) < COLS) && (int'(Ynum) < ROWS);
    assign wr_ok    = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);
    assign rd_idx   = IW'(int'(Ynum) * COLS + int'(Xnum));
    assign wr_idx   = IW'(int'(wr_y) * COLS + int'(wr_x));
    // A load request in the same cycle takes priority and drops the write.
    assign wr_fire  = (state == IDLE) && wr_en && !load_req && wr_ok;
    assign old_code = cells[wr_idx];
    assign busy     = (state == LOAD);

    // Cell storage carries no reset; the post-reset load rewrites every cell.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            cells[load_idx] <= rom_code;
        end else if (wr_fire) begin
            cells[wr_idx] <= wr_type;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            load_idx     <= '0;
            load_lvl     <= '0;
            Tile_Type    <= '0;
            target_count <= '0;
            level_done   <= 1'b0;
        end else begin
            level_done <= (state == IDLE) && (target_count == '0);

            // Reads are blanked for every cycle the FSM will spend in LOAD.
            if (state == LOAD || load_req || !rd_ok) begin
                Tile_Type <= '0;
            end else begin
                Tile_Type <= cells[rd_idx];
            end

            case (state)
                LOAD: begin
                    if (rom_code == TGT) begin
                        target_count <= target_count + CW'(1);
                    end
                    if (load_idx == IW'(CELLS-1)) begin
                        state <= IDLE;
                    end else begin
                        load_idx <= load_idx + IW'(1);
                    end
                end
                IDLE: begin
                    if (load_req) begin
                        load_lvl     <= (int'(level_sel) < NUM_LEVELS) ? level_sel : '0;
                        load_idx     <= '0;
                        target_count <= '0;
                        state        <= LOAD;
                    end else if (wr_fire) begin
                        if (old_code == TGT && wr_type != TGT) begin
                            target_count <= target_count - CW'(1);
                        end else if (old_code != TGT && wr_type == TGT) begin
                            target_count <= target_count + CW'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/tile_map.md
TILE_MAP -- requirements
Module: tile_map

Interface
REQ-001 Parameter COLS, default 8, grid width in tiles.
REQ-002 Parameter ROWS, default 8, grid height in tiles.
REQ-003 Parameter TYPE_W, default 2, tile-type code width.
REQ-004 Parameter NUM_LEVELS, default 2, number of stored initial level images.
REQ-005 Parameter TARGET_TYPE, default 1, tile code counted as a collectible target.
REQ-006 The module SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Xnum  in  XW=$clog2(COLS)  read column.
- Ynum  in  YW=$clog2(ROWS)  read row.
- Tile_Type  out  TYPE_W  registered tile code at (Xnum,Ynum).
- wr_en  in  1  tile write strobe.
- wr_x  in  XW  write column.
- wr_y  in  YW  write row.
- wr_type  in  TYPE_W  new tile code.
- load_req  in  1  single-cycle request to reload a level image.
- level_sel  in  $clog2(NUM_LEVELS)  level image to load.
- busy  out  1  load in progress.
- target_count  out  $clog2(COLS*ROWS+1)  number of cells holding TARGET_TYPE.
- level_done  out  1  no targets remain.

Function
REQ-007 Storage SHALL be COLS*ROWS cells of TYPE_W bits, row-major index y*COLS+x.
REQ-008 FSM SHALL have states LOAD and IDLE only.
REQ-009 LOAD SHALL copy one cell per cycle from the latched level image, index 0 to COLS*ROWS-1, then go to IDLE; duration is exactly COLS*ROWS cycles.
REQ-010 During LOAD, target_count SHALL start at 0 and increment for each copied cell equal to TARGET_TYPE.
REQ-011 In IDLE, load_req SHALL latch level_sel, clear the index, and enter LOAD on the next cycle.
REQ-012 load_req during LOAD SHALL be ignored.
REQ-013 level_sel >= NUM_LEVELS SHALL load level 0.
REQ-014 busy SHALL be 1 exactly while the state is LOAD.
REQ-015 Tile_Type SHALL have one-cycle latency from Xnum/Ynum.
REQ-016 Tile_Type SHALL be 0 for out-of-range coordinates, and while busy.
REQ-017 In IDLE, wr_en SHALL update cell (wr_x,wr_y) at the clock edge; writes to out-of-range coordinates SHALL be ignored.
REQ-018 wr_en SHALL be ignored during LOAD.
REQ-019 If wr_en and load_req are both high in IDLE, the load SHALL win and the write SHALL be dropped.
REQ-020 On a write, target_count SHALL behave as follows:
- old value TARGET_TYPE, new value different: decrement by 1.
- old value different, new value TARGET_TYPE: increment by 1.
- otherwise: unchanged.
REQ-021 A read and a write to the same cell in the same cycle SHALL return the old value (read-before-write).
REQ-022 level_done SHALL be registered and SHALL equal 1 in the cycle after the FSM is in IDLE with target_count==0; it SHALL be 0 otherwise.
REQ-023 A level image with zero targets SHALL raise level_done one cycle after LOAD ends.

Reset
REQ-024 Reset SHALL force the following, asynchronously:
- state LOAD, index 0, latched level 0, busy 1.
- Tile_Type 0, target_count 0, level_done 0.
REQ-025 Level-0 load SHALL begin on the first clock edge after reset deasserts, with no load_req needed.
REQ-026 Reset asserted mid-LOAD or mid-write SHALL abort the operation and restart the level-0 load on release.
REQ-027 Cell storage SHALL NOT require reset.

Structure
REQ-028 Package tile_pkg SHALL hold:
- tile code constants: EMPTY=0, TARGET=1.
- the FSM state enum.
- the level image constant arrays.
REQ-029 Level level 0 image SHALL have row 7, columns 0..5 set to TARGET, and all other cells EMPTY.
REQ-030 Level level 1 image SHALL be all EMPTY.
REQ-031 One sub-module, tile_level_rom, SHALL provide the combinational image lookup (level, index) -> code.

Verification
REQ-032 Reset release -> busy=1 for exactly 64 cycles, then busy=0, target_count=6, level_done=0.
REQ-033 After load, read (5,7) -> Tile_Type=1 one cycle later; read (6,7) -> 0.
REQ-034 Write EMPTY to (0..5,7) in six writes -> target_count decrements 6 to 0; level_done=1 on the following cycle.
REQ-035 Rewrite TARGET at (2,7) -> target_count=1 and level_done=0; rewriting TARGET at (2,7) again -> count unchanged.
REQ-036 load_req with level_sel=1 plus wr_en in the same cycle -> write dropped, 64-cycle load, then target_count=0 and level_done=1.
REQ-037 Reset pulsed at load cycle 30 -> full 64-cycle level-0 reload restarts and ends with target_count=6.
